mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
MEM-stage data-memory access controller. It consumes the EX/MEM pipeline register outputs and runs a req/ack transaction to the data memory for each load or store. It aligns byte lanes for stores and sign/zero-extends load data. It asserts Stall, which the hazard unit uses to hold Ld low on PC, IF/ID, ID/EX and EX/MEM until the access completes.

Parameters:
TIMEOUT, 255, max cycles in ACCESS without mem_ack before a bus error (1..255; counter is 8 bits)

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous, active-high reset
MEM_MemRead  input  1  load request from EX/MEM register
MEM_MemWrite  input  1  store request from EX/MEM register
MEM_ALUResult  input  32  byte address
MEM_ReadData2  input  32  store data (rt)
MEM_Datatype  input  2  00 word, 01 half signed, 10 byte signed, 11 byte unsigned
mem_req  output  1  memory request
mem_we  output  1  1 = write
mem_addr  output  32  word address ({addr[31:2],2'b00})
mem_be  output  4  byte enables, bit0 = bits 7:0 (little-endian)
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  single-cycle completion pulse
mem_rdata  input  32  read word, valid with mem_ack
MEM_LoadData  output  32  extended load result, to MEM/WB register
Stall  output  1  pipeline hold
AlignErr  output  1  one-cycle misaligned-access pulse
BusErr  output  1  one-cycle timeout pulse

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-high.
- Reset values:
  - state IDLE
  - mem_req, mem_we 0; mem_addr, mem_be, mem_wdata 0
  - MEM_LoadData 0
  - AlignErr, BusErr 0; timeout counter 0
- Access detection:
  - acc = MEM_MemRead | MEM_MemWrite.
  - If both MemRead and MemWrite are 1, the access is a read and the write is ignored.
- Alignment:
  - word needs addr[1:0] = 0; half needs addr[0] = 0; byte is always aligned.
- Stall (combinational):
  - 1 in IDLE when acc is 1 and the access is aligned.
  - 1 in ACCESS.
  - 0 in DONE and otherwise.
- IDLE:
  - Aligned acc: latch addr, we, be, wdata and Datatype into the output/holding registers; mem_req is 1 next cycle; go to ACCESS.
  - Misaligned acc: no request, AlignErr pulses next cycle, go to DONE. MEM_LoadData is unchanged.
  - mem_ack in IDLE is ignored.
- Store byte enables and data:
  - word: be 1111, wdata = rd2.
  - half: be 0011 if addr[1] = 0, else 1100; wdata = {2{rd2[15:0]}}.
  - byte: be = 1 << addr[1:0]; wdata = {4{rd2[7:0]}}.
- Load: mem_be is 1111 regardless of Datatype.
- ACCESS:
  - mem_req is held at 1 and mem_addr/we/be/wdata are stable; the counter increments every cycle.
  - On mem_ack, for a read: select a lane by latched addr[1:0] and extend per the latched Datatype. Half selects [15:0] or [31:16]; byte selects lane n. The result is registered into MEM_LoadData; go to DONE.
  - On mem_ack for a write: MEM_LoadData is unchanged.
  - If the counter reaches TIMEOUT with no ack: BusErr pulses, MEM_LoadData is set to 0, go to DONE.
- DONE (exactly 1 cycle):
  - mem_req 0, Stall 0; the EX/MEM register advances at this edge; go to IDLE.
  - No new access starts in DONE, so back-to-back memory instructions have 1 bubble cycle between transactions.
  - MEM_LoadData is valid in DONE and holds until the next capture.
- Load latency: minimum 3 cycles from IDLE detect to DONE when mem_ack arrives in the first ACCESS cycle.
- Counter: cleared on entry to ACCESS.
- Reset mid-transaction: everything returns to reset values immediately. A late mem_ack arriving in IDLE is ignored.

Test Plan:
1. lw at 0x100, mem_rdata 0xDEADBEEF, ack 3 cycles after req -> Stall high 4 cycles (1 IDLE + 3 ACCESS); in DONE, MEM_LoadData = 0xDEADBEEF and Stall = 0; mem_be = 1111; mem_addr = 0x100.
2. sb at 0x103 with rd2 = 0x000000A5 -> mem_we = 1, mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x100; MEM_LoadData unchanged.
3. Loads of word 0x80FF7F01 at 0x200:
   - lb at 0x200 -> 0x00000001.
   - lb at 0x203 -> 0xFFFFFF80.
   - lbu at 0x203 -> 0x00000080.
   - lh at 0x202 -> 0xFFFF80FF.
4. lh at 0x201 -> no mem_req, AlignErr pulses 1 cycle, Stall never asserted; same result for lw at 0x102.
5. TIMEOUT = 4, no ack -> mem_req high 4 cycles, then BusErr pulse, MEM_LoadData = 0, Stall drops, FSM returns to IDLE.
6. Rst asserted in the 2nd ACCESS cycle, then ack 1 cycle after Rst is released -> mem_req falls without waiting for a clock; ack ignored; state IDLE; all outputs 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: runs one req/ack transaction per
// load/store, aligns store byte lanes, extends load data and stalls the
// pipeline until the access completes.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [31:0] MEM_ALUResult,
   input  logic [31:0] MEM_ReadData2,
   input  logic [1:0]  MEM_Datatype,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] MEM_LoadData,
   output logic        Stall,
   output logic        AlignErr,
   output logic        BusErr
);

   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;
   localparam int unsigned CW = 8;

   localparam logic [1:0] DT_WORD  = 2'b00;
   localparam logic [1:0] DT_HALF  = 2'b01;
   localparam logic [1:0] DT_BYTE  = 2'b10;
   localparam logic [1:0] DT_UBYTE = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    dt_q;
   logic [1:0]    off_q;

   logic          acc_c;
   logic          rd_c;
   logic          aligned_c;
   logic [BW-1:0] be_c;
   logic [DW-1:0] wdata_c;
   logic [DW-1:0] lane_c;
   logic [DW-1:0] ld_c;

   // Decode the incoming access: direction, alignment, store lanes and data.
   always_comb begin
      acc_c     = MEM_MemRead | MEM_MemWrite;
      rd_c      = MEM_MemRead;
      aligned_c = 1'b1;
      be_c      = 4'b1111;
      wdata_c   = MEM_ReadData2;
      case (MEM_Datatype)
         DT_WORD: begin
            aligned_c = (MEM_ALUResult[1:0] == 2'b00);
            be_c      = 4'b1111;
            wdata_c   = MEM_ReadData2;
         end
         DT_HALF: begin
            aligned_c = ~MEM_ALUResult[0];
            be_c      = MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
            wdata_c   = {2{MEM_ReadData2[15:0]}};
         end
         default: begin
            aligned_c = 1'b1;
            be_c      = BW'(4'b0001 << MEM_ALUResult[1:0]);
            wdata_c   = {4{MEM_ReadData2[7:0]}};
         end
      endcase
      // loads always fetch the whole word
      if (rd_c) begin
         be_c    = 4'b1111;
         wdata_c = '0;
      end
   end

   // Select the addressed lane of the returned word and extend it.
   always_comb begin
      lane_c = mem_rdata >> {off_q, 3'b000};
      case (dt_q)
         DT_WORD:  ld_c = mem_rdata;
         DT_HALF:  ld_c = {{16{lane_c[15]}}, lane_c[15:0]};
         DT_BYTE:  ld_c = {{24{lane_c[7]}}, lane_c[7:0]};
         DT_UBYTE: ld_c = {24'd0, lane_c[7:0]};
         default:  ld_c = mem_rdata;
      endcase
   end

   // Hold the pipeline while an aligned access is pending or in flight.
   assign Stall = ((state_q == IDLE) & acc_c & aligned_c) | (state_q == ACCESS);

   // Transaction FSM with registered bus, load result and error pulses.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         dt_q         <= '0;
         off_q        <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
         MEM_LoadData <= '0;
         AlignErr     <= 1'b0;
         BusErr       <= 1'b0;
      end else begin
         AlignErr <= 1'b0;
         BusErr   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (acc_c) begin
                  if (aligned_c) begin
                     mem_req   <= 1'b1;
                     mem_we    <= ~rd_c;
                     mem_addr  <= {MEM_ALUResult[31:2], 2'b00};
                     mem_be    <= be_c;
                     mem_wdata <= wdata_c;
                     dt_q      <= MEM_Datatype;
                     off_q     <= MEM_ALUResult[1:0];
                     cnt_q     <= '0;
                     state_q   <= ACCESS;
                  end else begin
                     AlignErr <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            ACCESS: begin
               cnt_q <= cnt_q + CW'(1);
               if (mem_ack) begin
                  if (!mem_we) begin
                     MEM_LoadData <= ld_c;
                  end
                  mem_req <= 1'b0;
                  state_q <= DONE;
               end else if ((cnt_q + CW'(1)) == CW'(TIMEOUT)) begin
                  BusErr       <= 1'b1;
                  MEM_LoadData <= '0;
                  mem_req      <= 1'b0;
                  state_q      <= DONE;
               end
            end
            DONE: begin
               // single bubble cycle; the EX/MEM register advances here
               state_q <= IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
